// File: rtl/ascii_num_parser_if.sv
// ascii_num_parser_if
//   Bundles the receive-FIFO read side and the parsed-result outputs of
//   ascii_num_parser.
//   Signals:
//     rx_empty      FIFO empty flag (head byte valid while 0)
//     rx_fifo_data  FIFO head byte
//     pop           one-cycle pulse removing the head byte
//     o_value       last accepted value (held between updates)
//     o_valid       one-cycle pulse, o_value refreshed in the same cycle
//     o_err         one-cycle pulse for a rejected line
//   Modports:
//     master  parser side (reads the FIFO, drives results)
//     slave   environment side (FIFO + result consumer)
interface ascii_num_parser_if;
  logic        rx_empty;
  logic [7:0]  rx_fifo_data;
  logic        pop;
  logic [11:0] o_value;
  logic        o_valid;
  logic        o_err;

  modport master (
    input  rx_empty,
    input  rx_fifo_data,
    output pop,
    output o_value,
    output o_valid,
    output o_err
  );

  modport slave (
    output rx_empty,
    output rx_fifo_data,
    input  pop,
    input  o_value,
    input  o_valid,
    input  o_err
  );
endinterface

// File: rtl/ascii_num_parser.sv
// ascii_num_parser
//   Reads ASCII decimal lines from a receive FIFO and reports their value.
//   A line is up to MAX_DIGITS digits terminated by CR or LF. Lines that are
//   too long, contain a non-digit, or exceed MAX_VALUE raise o_err; a
//   terminator with no digits (e.g. the LF of a CR/LF pair) is ignored.
//   Each byte takes a fetch cycle and a process cycle, so pop never fires on
//   consecutive cycles.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous reset, active-low
//     bus  ascii_num_parser_if.master (FIFO read + result outputs)
module ascii_num_parser #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_VALUE  = 4095
) (
  input  logic               clk,
  input  logic               rst,
  ascii_num_parser_if.master bus
);

  localparam int ACC_W = 14;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(MAX_VALUE);

  typedef enum logic [2:0] {
    FETCH,
    PROC,
    DISCARD_FETCH,
    DISCARD_PROC,
    REPORT
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       byte_q, byte_nxt;
  logic             pop_q, pop_nxt;
  logic [11:0]      value_q, value_nxt;
  logic             valid_q, valid_nxt;
  logic             err_q, err_nxt;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  // For a digit byte, b - 0x30 is simply its low nibble.
  function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] a,
                                                input logic [7:0]       b);
    return ACC_W'(a * ACC_W'(10)) + ACC_W'(b[3:0]);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      acc     <= '0;
      cnt     <= '0;
      byte_q  <= '0;
      pop_q   <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      byte_q  <= byte_nxt;
      pop_q   <= pop_nxt;
      value_q <= value_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    byte_nxt  = byte_q;
    pop_nxt   = 1'b0;
    value_nxt = value_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      // Both fetch states latch the head byte; the registered pop lands in
      // the following process cycle, after which the FIFO head advances.
      FETCH, DISCARD_FETCH: begin
        if (!bus.rx_empty) begin
          byte_nxt  = bus.rx_fifo_data;
          pop_nxt   = 1'b1;
          state_nxt = (state == FETCH) ? PROC : DISCARD_PROC;
        end
      end

      PROC: begin
        if (is_digit(byte_q)) begin
          if (cnt < CNT_MAX) begin
            acc_nxt   = acc_step(acc, byte_q);
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = FETCH;
          end else begin
            state_nxt = DISCARD_FETCH;
          end
        end else if (is_term(byte_q)) begin
          if (cnt == '0) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = FETCH;
          end else if (acc <= ACC_MAX) begin
            value_nxt = acc[11:0];
            valid_nxt = 1'b1;
            state_nxt = REPORT;
          end else begin
            err_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = FETCH;
          end
        end else begin
          state_nxt = DISCARD_FETCH;
        end
      end

      DISCARD_PROC: begin
        if (is_term(byte_q)) begin
          err_nxt   = 1'b1;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = FETCH;
        end else begin
          state_nxt = DISCARD_FETCH;
        end
      end

      // o_valid is high during this cycle; no fetch so no pop here.
      REPORT: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = FETCH;
      end

      default: state_nxt = FETCH;
    endcase
  end

  assign bus.pop     = pop_q;
  assign bus.o_value = value_q;
  assign bus.o_valid = valid_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_ascii_num_parser.sv
// tb_ascii_num_parser
//   Directed bench for ascii_num_parser: a queue models the receive FIFO,
//   a negedge monitor counts pops and result pulses, and each directed line
//   is checked against hand-computed counts and values.
module tb_ascii_num_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ascii_num_parser_if bus ();

  ascii_num_parser #(
    .MAX_DIGITS(4),
    .MAX_VALUE (4095)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_pop = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int n_adj = 0;
  int last_lat = -1;
  int last_pop_cyc = -100;
  int pop_cyc[$];
  logic pop_prev = 1'b0;

  int b_pop, b_valid, b_err, b_idx;

  // FIFO model + monitor. The pop pulse is high for a whole cycle, so the
  // head is removed at the negedge of that cycle and the next byte is
  // presented before the following fetch edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.pop === 1'b1) begin
      n_pop++;
      pop_cyc.push_back(cyc);
      if (pop_prev) n_adj++;
      last_pop_cyc = cyc;
      if (q.size() > 0) void'(q.pop_front());
    end
    pop_prev = (bus.pop === 1'b1);
    if (bus.o_valid === 1'b1) begin
      n_valid++;
      last_lat = cyc - last_pop_cyc;
    end
    if (bus.o_err === 1'b1) begin
      n_err++;
      last_lat = cyc - last_pop_cyc;
    end
    if (bus.o_valid === 1'b1 && bus.o_err === 1'b1) n_both++;
    bus.rx_empty     = (q.size() == 0);
    bus.rx_fifo_data = (q.size() > 0) ? q[0] : 8'h00;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic push_b(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic mark();
    b_pop   = n_pop;
    b_valid = n_valid;
    b_err   = n_err;
    b_idx   = pop_cyc.size();
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_drain"}, q.size(), 0);
  endtask

  task automatic expect_counts(input string tag, input int pops, input int vld,
                               input int err);
    check({tag, "_pops"},  n_pop - b_pop, pops);
    check({tag, "_valid"}, n_valid - b_valid, vld);
    check({tag, "_err"},   n_err - b_err, err);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop",   bus.pop, 0);
    check("rst_value", bus.o_value, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_err",   bus.o_err, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // "123" CR
    mark();
    push_str("123");
    push_b(8'h0D);
    drain("t123");
    expect_counts("t123", 4, 1, 0);
    check("t123_value", bus.o_value, 123);
    check("t123_lat", last_lat, 1);
    for (int i = 1; i < 4; i++)
      check("t123_gap", pop_cyc[b_idx+i] - pop_cyc[b_idx+i-1], 2);

    // "4095" CR LF: LF is an empty line and must stay silent
    mark();
    push_str("4095");
    push_b(8'h0D);
    push_b(8'h0A);
    drain("t4095");
    expect_counts("t4095", 6, 1, 0);
    check("t4095_value", bus.o_value, 4095);

    // "4096" CR: out of range, value held
    mark();
    push_str("4096");
    push_b(8'h0D);
    drain("t4096");
    expect_counts("t4096", 5, 0, 1);
    check("t4096_value", bus.o_value, 4095);
    check("t4096_lat", last_lat, 1);

    // "12345" LF: too many digits
    mark();
    push_str("12345");
    push_b(8'h0A);
    drain("t12345");
    expect_counts("t12345", 6, 0, 1);
    check("t12345_value", bus.o_value, 4095);
    check("t12345_lat", last_lat, 1);

    mark();
    push_str("7");
    push_b(8'h0D);
    drain("t7");
    expect_counts("t7", 2, 1, 0);
    check("t7_value", bus.o_value, 7);

    // "1A2" CR: illegal character
    mark();
    push_str("1A2");
    push_b(8'h0D);
    drain("t1a2");
    expect_counts("t1a2", 4, 0, 1);
    check("t1a2_value", bus.o_value, 7);

    // lone CR then "0000" CR: exactly MAX_DIGITS digits is accepted
    mark();
    push_b(8'h0D);
    push_str("0000");
    push_b(8'h0D);
    drain("t0000");
    expect_counts("t0000", 6, 1, 0);
    check("t0000_value", bus.o_value, 0);

    mark();
    push_str("42");
    push_b(8'h0A);
    drain("t42");
    expect_counts("t42", 3, 1, 0);
    check("t42_value", bus.o_value, 42);

    // "98" then reset mid-line, then "5" CR
    push_str("98");
    drain("t98");
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_pop",   bus.pop, 0);
    check("mid_rst_value", bus.o_value, 0);
    check("mid_rst_valid", bus.o_valid, 0);
    check("mid_rst_err",   bus.o_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mark();
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_pops", n_pop - b_pop, 0);
    push_str("5");
    push_b(8'h0D);
    drain("t5");
    expect_counts("t5", 2, 1, 0);
    check("t5_value", bus.o_value, 5);

    // idle FIFO
    mark();
    repeat (100) @(posedge clk);
    #1;
    expect_counts("idle", 0, 0, 0);
    check("idle_value", bus.o_value, 5);

    check("valid_err_overlap", n_both, 0);
    check("pop_back_to_back", n_adj, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
